// File: rtl/soc_simple_clkgen_multi.sv
// Multi-channel DDS clock-enable generator (tick + square level per channel) with a lock qualifier.
// Defining CLKGEN_PHASE_ALIGN_EN adds an 'align' input that re-phases every channel at once.
module soc_simple_clkgen_multi #(
   parameter int NUM_CH      = 4,
   parameter int ACC_W       = 16,
   parameter int DEFAULT_INC = 16384,
   parameter int LOCK_CYCLES = 64,
   parameter int CH_W        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
   input  logic              refclk,
   input  logic              rst,
   input  logic              cfg_valid,
   output logic              cfg_ready,
   input  logic [CH_W-1:0]   cfg_ch,
   input  logic [ACC_W-1:0]  cfg_inc,
`ifdef CLKGEN_PHASE_ALIGN_EN
   input  logic              align,
`endif
   output logic [NUM_CH-1:0] tick,
   output logic [NUM_CH-1:0] level,
   output logic              locked
);

   localparam int CNT_W = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LOCK_CYCLES - 1);
   localparam logic [CH_W:0]    NUM_CH_L = (CH_W + 1)'(NUM_CH);

   typedef enum logic {LOCKING, LOCKED} lock_state_t;

   lock_state_t       lock_state;
   logic [CNT_W-1:0]  lock_cnt;
   logic              pend_valid;
   logic [CH_W-1:0]   pend_ch;
   logic [ACC_W-1:0]  pend_inc;
   logic [NUM_CH-1:0] apply_vec;
   logic              in_range;
   logic              accept;
   logic              align_now;

`ifdef CLKGEN_PHASE_ALIGN_EN
   assign align_now = align;
`else
   assign align_now = 1'b0;
`endif

   assign cfg_ready = ~pend_valid;
   assign in_range  = ({1'b0, cfg_ch} < NUM_CH_L);
   assign accept    = cfg_valid & cfg_ready & in_range;

   genvar gi;
   generate
      for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
         logic [ACC_W-1:0] acc_reg;
         logic [ACC_W-1:0] inc_reg;
         logic             tick_reg;
         logic             level_reg;
         logic [ACC_W:0]   sum;
         logic             hit;

         assign sum = {1'b0, acc_reg} + {1'b0, inc_reg};
         assign hit = pend_valid && (pend_ch == CH_W'(gi));
         // Swap the increment only on the wrapping add so no runt period appears;
         // a stopped channel never wraps, so it takes the update straight away.
         assign apply_vec[gi] = hit && (align_now || sum[ACC_W] || (inc_reg == '0));

         always_ff @(posedge refclk or posedge rst) begin
            if (rst) begin
               acc_reg   <= '0;
               inc_reg   <= ACC_W'(DEFAULT_INC);
               tick_reg  <= 1'b0;
               level_reg <= 1'b0;
            end else begin
               if (apply_vec[gi]) begin
                  inc_reg <= pend_inc;
               end
               if (align_now) begin
                  acc_reg   <= '0;
                  tick_reg  <= 1'b0;
                  level_reg <= 1'b0;
               end else begin
                  acc_reg   <= sum[ACC_W-1:0];
                  tick_reg  <= sum[ACC_W];
                  level_reg <= sum[ACC_W-1];
               end
            end
         end

         assign tick[gi]  = tick_reg;
         assign level[gi] = level_reg;
      end
   endgenerate

   always_ff @(posedge refclk or posedge rst) begin
      if (rst) begin
         pend_valid <= 1'b0;
         pend_ch    <= '0;
         pend_inc   <= '0;
      end else begin
         if (|apply_vec) begin
            pend_valid <= 1'b0;
         end
         if (accept) begin
            pend_valid <= 1'b1;
            pend_ch    <= cfg_ch;
            pend_inc   <= cfg_inc;
         end
      end
   end

   // Settle counter only runs once nothing is pending, so relock is timed from application.
   always_ff @(posedge refclk or posedge rst) begin
      if (rst) begin
         lock_state <= LOCKING;
         lock_cnt   <= '0;
         locked     <= 1'b0;
      end else if (accept || align_now) begin
         lock_state <= LOCKING;
         lock_cnt   <= '0;
         locked     <= 1'b0;
      end else begin
         case (lock_state)
            LOCKING: begin
               if (pend_valid) begin
                  lock_cnt <= '0;
               end else if (lock_cnt == CNT_LAST) begin
                  lock_state <= LOCKED;
                  locked     <= 1'b1;
               end else begin
                  lock_cnt <= lock_cnt + CNT_W'(1);
               end
            end
            LOCKED: begin
               locked <= 1'b1;
            end
            default: begin
               lock_state <= LOCKING;
               locked     <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_soc_simple_clkgen_multi.sv
// Directed bench for soc_simple_clkgen_multi (3 channels, 16-bit accumulators, default inc 16384).
// Covers the CLKGEN_PHASE_ALIGN_EN feature when that macro is defined for the build.
module tb_soc_simple_clkgen_multi;

   logic       refclk = 1'b0;
   logic       rst;
   logic       cfg_valid;
   logic       cfg_ready;
   logic [1:0] cfg_ch;
   logic [15:0] cfg_inc;
   logic [2:0] tick;
   logic [2:0] level;
   logic       locked;
`ifdef CLKGEN_PHASE_ALIGN_EN
   logic       align;
`endif

   int total = 0;
   int bad   = 0;
   int cyc   = 0;

   soc_simple_clkgen_multi #(
      .NUM_CH(3), .ACC_W(16), .DEFAULT_INC(16384), .LOCK_CYCLES(64)
   ) dut (
      .refclk(refclk),
      .rst(rst),
      .cfg_valid(cfg_valid),
      .cfg_ready(cfg_ready),
      .cfg_ch(cfg_ch),
      .cfg_inc(cfg_inc),
`ifdef CLKGEN_PHASE_ALIGN_EN
      .align(align),
`endif
      .tick(tick),
      .level(level),
      .locked(locked)
   );

   always #5 refclk = ~refclk;

   initial begin
      #100000;
      $display("FAIL watchdog cyc=%0d got=running want=finished", cyc);
      $fatal(1, "timeout");
   end

   // Advance one refclk edge and settle; cyc counts edges since the last reset release.
   task automatic step();
      @(posedge refclk);
      #1;
      cyc++;
   endtask

   task automatic drive_req(input logic [1:0] ch, input logic [15:0] inc);
      cfg_valid = 1'b1;
      cfg_ch    = ch;
      cfg_inc   = inc;
      $display("cfg request ch=%0d inc=%0d cyc=%0d", ch, inc, cyc);
   endtask

   task automatic test_reset();
      logic [2:0] exp_t, exp_l;
      rst = 1'b1; cfg_valid = 1'b0; cfg_ch = '0; cfg_inc = '0;
`ifdef CLKGEN_PHASE_ALIGN_EN
      align = 1'b0;
`endif
      repeat (3) step();
      total++; if (tick !== 3'b000) begin bad++; $display("FAIL reset_tick got=%b want=000", tick); end
      total++; if (level !== 3'b000) begin bad++; $display("FAIL reset_level got=%b want=000", level); end
      total++; if (locked !== 1'b0) begin bad++; $display("FAIL reset_locked got=%b want=0", locked); end
      total++; if (cfg_ready !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b want=1", cfg_ready); end
      rst = 1'b0; cyc = 0;
      for (int e = 1; e <= 64; e++) begin
         step();
         exp_t = (e % 4 == 0) ? 3'b111 : 3'b000;
         exp_l = (e % 4 >= 2) ? 3'b111 : 3'b000;
         total++; if (tick !== exp_t) begin bad++; $display("FAIL default_tick cyc=%0d got=%b want=%b", cyc, tick, exp_t); end
         total++; if (level !== exp_l) begin bad++; $display("FAIL default_level cyc=%0d got=%b want=%b", cyc, level, exp_l); end
         total++; if (locked !== (e >= 64)) begin bad++; $display("FAIL initial_lock cyc=%0d got=%b want=%b", cyc, locked, (e >= 64)); end
      end
      $display("reset defaults checked through cyc=%0d", cyc);
   endtask

   task automatic test_reprogram();
      logic [2:0] exp_t;
      step();                      // 65: ch1 mid-period
      drive_req(2'd1, 16'd8192);
      step();                      // 66: transfer
      cfg_valid = 1'b0;
      total++; if (cfg_ready !== 1'b0) begin bad++; $display("FAIL reprog_ready_low got=%b want=0", cfg_ready); end
      total++; if (locked !== 1'b0) begin bad++; $display("FAIL reprog_lock_drop got=%b want=0", locked); end
      step();                      // 67
      total++; if (cfg_ready !== 1'b0) begin bad++; $display("FAIL reprog_ready_hold got=%b want=0", cfg_ready); end
      step();                      // 68: ch1 wraps, update applied
      total++; if (tick !== 3'b111) begin bad++; $display("FAIL reprog_wrap_tick got=%b want=111", tick); end
      total++; if (cfg_ready !== 1'b1) begin bad++; $display("FAIL reprog_ready_back got=%b want=1", cfg_ready); end
      for (int e = 69; e <= 132; e++) begin
         step();
         exp_t[0] = (e % 4 == 0);
         exp_t[1] = ((e - 68) % 8 == 0);
         exp_t[2] = (e % 4 == 0);
         total++; if (tick !== exp_t) begin bad++; $display("FAIL reprog_tick cyc=%0d got=%b want=%b", cyc, tick, exp_t); end
         total++; if (level[1] !== ((e - 68) % 8 >= 4)) begin bad++; $display("FAIL reprog_level1 cyc=%0d got=%b want=%b", cyc, level[1], ((e - 68) % 8 >= 4)); end
         total++; if (locked !== (e >= 132)) begin bad++; $display("FAIL reprog_relock cyc=%0d got=%b want=%b", cyc, locked, (e >= 132)); end
      end
      $display("reprogram ch1 checked through cyc=%0d", cyc);
   endtask

   task automatic test_stop_restart();
      step();                      // 133
      drive_req(2'd0, 16'd0);
      step();                      // 134: transfer
      cfg_valid = 1'b0;
      total++; if (locked !== 1'b0) begin bad++; $display("FAIL stop_lock_drop got=%b want=0", locked); end
      step();                      // 135
      step();                      // 136: ch0 wraps, inc becomes 0
      total++; if (tick[0] !== 1'b1) begin bad++; $display("FAIL stop_last_tick got=%b want=1", tick[0]); end
      total++; if (cfg_ready !== 1'b1) begin bad++; $display("FAIL stop_ready got=%b want=1", cfg_ready); end
      for (int e = 137; e <= 236; e++) begin
         step();
         total++; if (tick[0] !== 1'b0) begin bad++; $display("FAIL stopped_tick cyc=%0d got=%b want=0", cyc, tick[0]); end
         total++; if (level[0] !== 1'b0) begin bad++; $display("FAIL stopped_level cyc=%0d got=%b want=0", cyc, level[0]); end
         if (e == 236) begin
            total++; if (locked !== 1'b1) begin bad++; $display("FAIL stop_relock cyc=%0d got=%b want=1", cyc, locked); end
         end
      end
      drive_req(2'd0, 16'd32768);
      step();                      // 237: transfer
      cfg_valid = 1'b0;
      total++; if (cfg_ready !== 1'b0) begin bad++; $display("FAIL restart_ready_low got=%b want=0", cfg_ready); end
      step();                      // 238: applied at once since ch0 was stopped
      total++; if (cfg_ready !== 1'b1) begin bad++; $display("FAIL restart_ready_back got=%b want=1", cfg_ready); end
      total++; if (tick[0] !== 1'b0) begin bad++; $display("FAIL restart_first got=%b want=0", tick[0]); end
      for (int e = 239; e <= 250; e++) begin
         step();
         total++; if (tick[0] !== ((e - 238) % 2 == 0)) begin bad++; $display("FAIL restart_tick cyc=%0d got=%b want=%b", cyc, tick[0], ((e - 238) % 2 == 0)); end
         total++; if (level[0] !== ((e - 238) % 2 == 1)) begin bad++; $display("FAIL restart_level cyc=%0d got=%b want=%b", cyc, level[0], ((e - 238) % 2 == 1)); end
      end
      $display("stop/restart ch0 checked through cyc=%0d", cyc);
   endtask

   task automatic test_out_of_range();
      logic [2:0] exp_t;
      while (cyc < 302) begin
         step();
         if (cyc == 301) begin
            total++; if (locked !== 1'b0) begin bad++; $display("FAIL oor_prelock cyc=%0d got=%b want=0", cyc, locked); end
         end
      end
      total++; if (locked !== 1'b1) begin bad++; $display("FAIL oor_locked cyc=%0d got=%b want=1", cyc, locked); end
      drive_req(2'd3, 16'd1234);
      for (int e = 303; e <= 311; e++) begin
         step();
         cfg_valid = 1'b0;
         exp_t[0] = ((e - 238) % 2 == 0);
         exp_t[1] = ((e - 68) % 8 == 0);
         exp_t[2] = (e % 4 == 0);
         total++; if (cfg_ready !== 1'b1) begin bad++; $display("FAIL oor_ready cyc=%0d got=%b want=1", cyc, cfg_ready); end
         total++; if (locked !== 1'b1) begin bad++; $display("FAIL oor_lock cyc=%0d got=%b want=1", cyc, locked); end
         total++; if (tick !== exp_t) begin bad++; $display("FAIL oor_tick cyc=%0d got=%b want=%b", cyc, tick, exp_t); end
      end
      $display("out-of-range request checked through cyc=%0d", cyc);
   endtask

   task automatic test_back_to_back();
      drive_req(2'd2, 16'd8192);
      step();                      // 312: transfer coincides with ch2 wrap
      total++; if (cfg_ready !== 1'b0) begin bad++; $display("FAIL b2b_ready1 got=%b want=0", cfg_ready); end
      total++; if (tick[2] !== 1'b1) begin bad++; $display("FAIL b2b_wrap312 got=%b want=1", tick[2]); end
      drive_req(2'd2, 16'd4096);   // held while the first is pending
      for (int e = 313; e <= 315; e++) begin
         step();
         total++; if (cfg_ready !== 1'b0) begin bad++; $display("FAIL b2b_hold cyc=%0d got=%b want=0", cyc, cfg_ready); end
      end
      step();                      // 316: first update applied
      total++; if (tick[2] !== 1'b1) begin bad++; $display("FAIL b2b_wrap316 got=%b want=1", tick[2]); end
      total++; if (cfg_ready !== 1'b1) begin bad++; $display("FAIL b2b_ready_back got=%b want=1", cfg_ready); end
      step();                      // 317: second request accepted
      cfg_valid = 1'b0;
      total++; if (cfg_ready !== 1'b0) begin bad++; $display("FAIL b2b_second_accept got=%b want=0", cfg_ready); end
      for (int e = 318; e <= 323; e++) begin
         step();
         total++; if (tick[2] !== 1'b0) begin bad++; $display("FAIL b2b_gap cyc=%0d got=%b want=0", cyc, tick[2]); end
         total++; if (cfg_ready !== 1'b0) begin bad++; $display("FAIL b2b_pending cyc=%0d got=%b want=0", cyc, cfg_ready); end
      end
      step();                      // 324: wrap at the 8192 rate, second update applied
      total++; if (tick[2] !== 1'b1) begin bad++; $display("FAIL b2b_wrap324 got=%b want=1", tick[2]); end
      total++; if (cfg_ready !== 1'b1) begin bad++; $display("FAIL b2b_ready_final got=%b want=1", cfg_ready); end
      for (int e = 325; e <= 340; e++) begin
         step();
         total++; if (tick[2] !== (e == 340)) begin bad++; $display("FAIL b2b_rate4096 cyc=%0d got=%b want=%b", cyc, tick[2], (e == 340)); end
      end
      $display("back-to-back requests checked through cyc=%0d", cyc);
   endtask

   task automatic test_async_reset();
      drive_req(2'd1, 16'd4096);
      step();                      // 341: transfer
      cfg_valid = 1'b0;
      total++; if (cfg_ready !== 1'b0) begin bad++; $display("FAIL ar_pending got=%b want=0", cfg_ready); end
      step();
      step();
      #3 rst = 1'b1;
      #1;
      total++; if (tick !== 3'b000) begin bad++; $display("FAIL ar_tick got=%b want=000", tick); end
      total++; if (level !== 3'b000) begin bad++; $display("FAIL ar_level got=%b want=000", level); end
      total++; if (locked !== 1'b0) begin bad++; $display("FAIL ar_locked got=%b want=0", locked); end
      total++; if (cfg_ready !== 1'b1) begin bad++; $display("FAIL ar_ready got=%b want=1", cfg_ready); end
      #1 rst = 1'b0;
      cyc = 0;
      for (int e = 1; e <= 8; e++) begin
         step();
         total++; if (tick !== ((e % 4 == 0) ? 3'b111 : 3'b000)) begin bad++; $display("FAIL ar_after_tick cyc=%0d got=%b want=%b", cyc, tick, ((e % 4 == 0) ? 3'b111 : 3'b000)); end
         total++; if (cfg_ready !== 1'b1) begin bad++; $display("FAIL ar_after_ready cyc=%0d got=%b want=1", cyc, cfg_ready); end
      end
      $display("async reset mid-pending checked through cyc=%0d", cyc);
   endtask

`ifdef CLKGEN_PHASE_ALIGN_EN
   task automatic test_align();
      drive_req(2'd1, 16'd0);
      step();                      // 9
      cfg_valid = 1'b0;
      step();
      step();
      step();                      // 12: ch1 stopped at wrap
      total++; if (cfg_ready !== 1'b1) begin bad++; $display("FAIL al_stop_ready got=%b want=1", cfg_ready); end
      drive_req(2'd1, 16'd16384);
      step();                      // 13
      cfg_valid = 1'b0;
      step();                      // 14: restarted, ch1 now 2 cycles behind
      total++; if (cfg_ready !== 1'b1) begin bad++; $display("FAIL al_restart_ready got=%b want=1", cfg_ready); end
      step();
      step();                      // 16
      total++; if (tick !== 3'b101) begin bad++; $display("FAIL al_skew16 got=%b want=101", tick); end
      step();
      step();                      // 18
      total++; if (tick !== 3'b010) begin bad++; $display("FAIL al_skew18 got=%b want=010", tick); end
      align = 1'b1;
      $display("align pulse cyc=%0d", cyc);
      step();                      // 19
      align = 1'b0;
      total++; if (tick !== 3'b000) begin bad++; $display("FAIL al_tick0 got=%b want=000", tick); end
      total++; if (level !== 3'b000) begin bad++; $display("FAIL al_level0 got=%b want=000", level); end
      total++; if (locked !== 1'b0) begin bad++; $display("FAIL al_unlock got=%b want=0", locked); end
      for (int e = 20; e <= 83; e++) begin
         step();
         if (e <= 23) begin
            total++; if (tick !== ((e == 23) ? 3'b111 : 3'b000)) begin bad++; $display("FAIL al_tick cyc=%0d got=%b want=%b", cyc, tick, ((e == 23) ? 3'b111 : 3'b000)); end
         end
         if (e == 21) begin
            total++; if (level !== 3'b111) begin bad++; $display("FAIL al_level cyc=%0d got=%b want=111", cyc, level); end
         end
         if (e >= 82) begin
            total++; if (locked !== (e == 83)) begin bad++; $display("FAIL al_relock cyc=%0d got=%b want=%b", cyc, locked, (e == 83)); end
         end
      end
      $display("phase align checked through cyc=%0d", cyc);
   endtask
`endif

   initial begin
      test_reset();
      test_reprogram();
      test_stop_restart();
      test_out_of_range();
      test_back_to_back();
      test_async_reset();
`ifdef CLKGEN_PHASE_ALIGN_EN
      test_align();
`endif
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/soc_simple_clkgen_multi.md
Name: soc_simple_clkgen_multi

Overview:
- Parametrised multi-channel clock-enable generator running entirely on one reference clock.
- Each channel is a fractional phase accumulator (DDS style) producing a one-cycle tick (clock enable) and a ~50% square level, at frequency f_refclk * inc / 2^ACC_W.
- Increments are reprogrammable at run time through a valid/ready port and updated glitch-free at channel wrap.
- A locked output qualifies all channels after reset or reprogramming; downstream logic gates on it.

Parameters:
- NUM_CH, 4, number of output channels (1..16).
- ACC_W, 16, accumulator and increment width in bits (8..32).
- DEFAULT_INC, 16384, reset increment for every channel (16384 at ACC_W=16 gives refclk/4).
- LOCK_CYCLES, 64, settle cycles before locked asserts (>=1).
- CH_W, $clog2(NUM_CH) with a minimum of 1, width of the channel select.

Ports:
- refclk  input  1  reference clock, all logic on its rising edge.
- rst  input  1  asynchronous, active-high reset.
- cfg_valid  input  1  config request valid.
- cfg_ready  output  1  block can accept a config request.
- cfg_ch  input  CH_W  target channel.
- cfg_inc  input  ACC_W  new increment value.
- tick  output  NUM_CH  per-channel one-cycle clock-enable pulse.
- level  output  NUM_CH  per-channel square wave, equal to the accumulator MSB.
- locked  output  1  all channels settled at their programmed rates.

Behaviour:
- Reset values:
  - acc[c]=0, inc[c]=DEFAULT_INC.
  - tick=0, level=0, locked=0, cfg_ready=1.
  - pending empty, lock counter=0.
- Accumulator:
  - Every cycle, acc[c] <= acc[c]+inc[c] mod 2^ACC_W.
  - tick[c] is the registered carry-out of that addition. It is high for exactly one cycle, in the cycle after the wrapping add.
  - level[c] is the registered MSB of the new acc.
- inc=0 stops the channel: acc holds, tick=0, level holds its value.
- inc=2^(ACC_W-1) gives tick every 2 cycles. Increments above that are legal and give irregular (aliased) ticks.
- Config handshake:
  - Transfer happens when cfg_valid & cfg_ready. ch/inc are captured into the single pending register and cfg_ready goes 0 the next cycle.
  - cfg_valid with cfg_ready=0 is ignored; the requester must hold it.
  - If cfg_ch >= NUM_CH: the request is accepted and discarded, cfg_ready stays 1, locked is unaffected.
- Applying a pending update:
  - It is applied in the cycle where the target channel's add produces a carry. The new inc is used from the next add, so no short or runt period occurs.
  - If the target's current inc=0, it is applied on the first cycle after capture.
  - cfg_ready returns to 1 the cycle after application.
  - Writing the same value as the current inc still follows the full pending/apply/relock path.
- Lock FSM, with states LOCKING and LOCKED:
  - LOCKING: the counter increments each cycle while no update is pending. It moves to LOCKED when the counter reaches LOCK_CYCLES-1, and locked=1 from that transition.
  - LOCKED to LOCKING on any accepted in-range request: locked=0 the cycle after the transfer, and the counter clears.
  - While pending, the counter holds at 0.
  - After reset release, locked rises LOCK_CYCLES cycles after the first refclk edge.
- Simultaneous events: a transfer in the same cycle as the target's wrap does not apply that cycle; the update waits for the next wrap.
- Reset mid-operation (async assert): all state returns to reset values immediately, including dropping any pending update, with no tick glitch.

Optional Feature:
- Macro CLKGEN_PHASE_ALIGN_EN.
- Defined:
  - Adds input port align (1 bit).
  - align=1 clears every acc to 0 on the next edge and forces tick=0 and level=0 that cycle.
  - Any pending update is applied immediately in the same cycle.
  - The lock counter restarts, locked=0 the next cycle, then relocks after LOCK_CYCLES.
  - After release, all channels with equal inc tick in the same cycle.
- Undefined: the align port is absent; channels keep their independent phases forever.

Test Plan:
- Reset defaults (ACC_W=16, DEFAULT_INC=16384): release rst.
  - tick[c] high every 4th cycle, the first one 4 cycles after release.
  - level toggles every 2 cycles.
  - locked=1 after 64 cycles.
- Reprogram: write ch1 inc=8192 at a mid-period point.
  - cfg_ready=0 until ch1's next wrap.
  - After it, ch1 ticks every 8 cycles with no period shorter than 4 or between 4 and 8.
  - locked drops the next cycle and returns 64 cycles after application.
  - Other channels are unchanged.
- Stop/restart: write ch0 inc=0 and the level value freezes; tick stays 0 for 100 cycles. Write ch0 inc=32768: applied next cycle, ticks every 2 cycles.
- Out-of-range: with NUM_CH=3, write cfg_ch=3 → cfg_ready stays 1, locked stays 1, no channel changes.
- Back-pressure and async reset:
  - Hold cfg_valid with a second request while the first is pending; it is accepted only after cfg_ready=1 and applied in order.
  - Assert rst mid-pending: outputs reach reset values without waiting for a refclk edge, and the pending value is never applied.
- With CLKGEN_PHASE_ALIGN_EN: channels with inc=16384 at skewed phases, pulse align → all ticks coincide 4 cycles later and locked relocks after 64 cycles.
